instr_mem_fetch: RTL and testbench
==================================

# instr_mem_fetch

Parametrised, word-organised instruction memory with a registered valid/ready fetch port, a program-load write port, fault reporting and flush support. It sits between the IF-stage PC logic and the IF/ID pipeline register. It replaces the combinational unbounded-array instruction ROM with a sized, stallable, loadable memory that has one cycle of read latency.

## Interface
Parameters:
- ADDR_W, 32, width of the byte address on the fetch port
- DEPTH, 1024, number of 32-bit instruction words (power of two, ≥ 4)
- NOP_WORD, 32'h0000_0013, word returned on a faulted fetch (addi x0,x0,0)

Ports (reset is asynchronous and active-low):
- clk  in  1  clock, all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request can be accepted this cycle
- req_addr  in  ADDR_W  byte address of the instruction
- resp_valid  out  1  response word valid
- resp_ready  in  1  consumer takes the response this cycle
- resp_data  out  32  fetched instruction (NOP_WORD on fault)
- resp_addr  out  ADDR_W  byte address that produced resp_data
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range
- flush  in  1  discard any held response and block acceptance this cycle
- load_en  in  1  write load_data into the array this cycle
- load_addr  in  $clog2(DEPTH)  word index for the load
- load_data  in  32  instruction word to store
- fetch_cnt  out  32  count of completed response handshakes

## Operation
- Storage: DEPTH × 32 array. Contents are not reset. They are written only through the load port.
- Word index = req_addr[$clog2(DEPTH)+1:2].
- Accept condition: req_valid && req_ready.
  - req_ready = !flush && !load_en && (!resp_valid || resp_ready).
- On accept, the output register captures the following values at the next edge:
  - resp_valid=1, resp_addr=req_addr.
  - If req_addr[1:0]≠0: resp_fault=01, resp_data=NOP_WORD. The misaligned check has priority.
  - Else if req_addr>>2 ≥ DEPTH: resp_fault=10, resp_data=NOP_WORD.
  - Else: resp_fault=00, resp_data=mem[index].
- Response held: while resp_valid && !resp_ready, resp_valid, resp_data, resp_addr and resp_fault hold stable and req_ready=0.
- Response consumed with no new accept: resp_valid→0 at the next edge. resp_data, resp_addr and resp_fault keep their last values.
- Back-to-back: when resp_ready=1, a new request is accepted in the same cycle. This gives one response per cycle.
- Flush: resp_valid→0 at the next edge regardless of resp_ready. No request is accepted during flush. A response handshake in the flush cycle still counts in fetch_cnt.
- Load: mem[load_addr]←load_data at the edge. A load blocks fetch acceptance in that cycle. A load and a flush may coincide; both take effect.
- Read-after-load: a fetch accepted in the cycle after a load to the same word returns the new data.
- fetch_cnt increments by 1 on each resp_valid && resp_ready. It wraps from 0xFFFF_FFFF to 0.
- Reset mid-operation: all outputs go to their reset values at once. Array contents are preserved.

## Timing
- Reset values: resp_valid=0, resp_data=0, resp_addr=0, resp_fault=00, fetch_cnt=0.
- req_ready is combinational. During reset it is 0 only if flush or load_en is high; otherwise it is 1 because resp_valid=0.
- Latency: request accepted at edge N → response visible after edge N, consumable in cycle N+1.
- Throughput: 1 fetch per cycle while resp_ready=1 and load_en=0.
- No combinational path from req_addr to resp_data.
- The only combinational path from resp_ready is to req_ready.
- Array read and write are both synchronous. The write port and read port never conflict, because a load blocks acceptance.

## Test plan
- Load then fetch: load words 0..3 = 0x00500093, 0x00132423, 0x0074AE03, 0x00848967; fetch addresses 0, 4, 8, 12 with resp_ready=1.
  - Expect 4 consecutive responses with those words, resp_fault=00, resp_addr matching, fetch_cnt=4.
- Back-pressure: fetch 0x4, hold resp_ready=0 for 3 cycles.
  - Expect resp_data=0x00132423 stable and req_ready=0 throughout.
  - After resp_ready=1, expect exactly one handshake and the next request accepted in the same cycle.
- Faults (DEPTH=1024): fetch 0x6 → resp_fault=01, data=0x00000013. Fetch 0x1000 → resp_fault=10, data=0x00000013. Fetch 0x1002 → resp_fault=01.
- Flush: response pending with resp_ready=0; assert flush for 1 cycle with req_valid=1.
  - Expect resp_valid=0 next cycle, no acceptance during flush, fetch_cnt unchanged.
- Load collision and read-after-load: load_en=1 with req_valid=1 → req_ready=0. Load word 5 = 0x00E00A6F, then fetch 0x14 the next cycle → 0x00E00A6F.
- Async reset mid-stream: drop rstn between edges with resp_valid=1.
  - Expect all outputs at reset values immediately.
  - After release, a fetch of 0x0 returns the previously loaded 0x00500093.

Source files
------------

// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_fetch : loadable word instruction memory, registered valid/ready fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_mem_fetch #(
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic [1:0]               resp_fault,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              fetch_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  logic [31:0]      r_mem [DEPTH];
  logic             w_accept;
  logic             w_handshake;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic [IDX_W-1:0] w_idx;

  assign w_idx        = req_addr[IDX_W+1:2];
  assign w_misaligned = (req_addr[1:0] != 2'b00);

  // Address bits above the word index decide the out-of-range fault.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign w_out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign req_ready   = !flush && !load_en && (!resp_valid || resp_ready);
  assign w_accept    = req_valid && req_ready;
  assign w_handshake = resp_valid && resp_ready;

  // Array has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_addr  <= '0;
      resp_fault <= FAULT_OK;
    end else if (w_accept) begin
      resp_valid <= 1'b1;
      resp_addr  <= req_addr;
      if (w_misaligned) begin
        resp_fault <= FAULT_ALIGN;
        resp_data  <= NOP_WORD;
      end else if (w_out_of_range) begin
        resp_fault <= FAULT_RANGE;
        resp_data  <= NOP_WORD;
      end else begin
        resp_fault <= FAULT_OK;
        resp_data  <= r_mem[w_idx];
      end
    end else if (flush || w_handshake) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt <= '0;
    end else if (w_handshake) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_mem_fetch : directed vector table plus randomized model-checked run
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instr_mem_fetch;

  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic [1:0]  resp_fault;
  logic        flush;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] fetch_cnt;

  instr_mem_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Transaction-level reference: memory image plus the one pending response.
  logic [31:0] mm [DEPTH];
  bit          kn [DEPTH];
  logic        m_valid;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  logic [1:0]  m_fault;
  logic [31:0] m_cnt;
  bit          m_known;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        le;
    logic [9:0]  la;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_data;
    logic [31:0] e_addr;
    logic [1:0]  e_f;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_addr  = 32'h0;
    m_fault = 2'b00;
    m_cnt   = 32'h0;
    m_known = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(m_valid));
    chk({tag, ".resp_addr"},  resp_addr, m_addr);
    chk({tag, ".resp_fault"}, 32'(resp_fault), 32'(m_fault));
    chk({tag, ".fetch_cnt"},  fetch_cnt, m_cnt);
    if (m_known) chk({tag, ".resp_data"}, resp_data, m_data);
  endtask

  // One clock cycle: drive, check ready before the edge, advance model, check after.
  task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                      input logic fl, input logic le, input logic [9:0] la,
                      input logic [31:0] ld, output logic rdy_seen);
    logic exp_rdy;
    int   w;
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
    flush      = fl;
    load_en    = le;
    load_addr  = la;
    load_data  = ld;
    #1;
    exp_rdy = !fl && !le && (!m_valid || rr);
    chk("model.req_ready", 32'(req_ready), 32'(exp_rdy));
    rdy_seen = req_ready;
    @(posedge clk);
    if (m_valid && rr) m_cnt = m_cnt + 32'd1;
    if (rv && exp_rdy) begin
      m_valid = 1'b1;
      m_addr  = ra;
      w       = int'(ra >> 2);
      if (ra % 4 != 0) begin
        m_fault = 2'b01; m_data = NOP; m_known = 1'b1;
      end else if (ra / 4 >= DEPTH) begin
        m_fault = 2'b10; m_data = NOP; m_known = 1'b1;
      end else begin
        m_fault = 2'b00; m_data = mm[w]; m_known = kn[w];
      end
    end else if (fl || (m_valid && rr)) begin
      m_valid = 1'b0;
    end
    if (le) begin
      mm[int'(la)] = ld;
      kn[int'(la)] = 1'b1;
    end
    #1;
    check_outputs("model");
  endtask

  initial begin
    logic        rdy;
    logic        rv, rr, fl, le;
    logic [31:0] ra;
    int          r;

    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = 32'h0;
      kn[i] = 1'b0;
    end
    model_reset();

    //               rv   ra           rr   fl   le   la     ld            rdy  v    data          addr         f      cnt
    tbl[0]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 10'd0, 32'h00500093, 1'b0, 1'b0, 32'h0,        32'h0,    2'b00, 32'd0};
    tbl[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 10'd1, 32'h00132423, 1'b0, 1'b0, 32'h0,        32'h0,    2'b00, 32'd0};
    tbl[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 10'd2, 32'h0074AE03, 1'b0, 1'b0, 32'h0,        32'h0,    2'b00, 32'd0};
    tbl[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 10'd3, 32'h00848967, 1'b0, 1'b0, 32'h0,        32'h0,    2'b00, 32'd0};
    tbl[4]  = '{1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h00500093, 32'h0,    2'b00, 32'd0};
    tbl[5]  = '{1'b1, 32'h4,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h00132423, 32'h4,    2'b00, 32'd1};
    tbl[6]  = '{1'b1, 32'h8,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h0074AE03, 32'h8,    2'b00, 32'd2};
    tbl[7]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h00848967, 32'hC,    2'b00, 32'd3};
    tbl[8]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b0, 32'h00848967, 32'hC,    2'b00, 32'd4};
    tbl[9]  = '{1'b1, 32'h6,    1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, NOP,          32'h6,    2'b01, 32'd4};
    tbl[10] = '{1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, NOP,          32'h1000, 2'b10, 32'd5};
    tbl[11] = '{1'b1, 32'h1002, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, NOP,          32'h1002, 2'b01, 32'd6};
    tbl[12] = '{1'b1, 32'h0,    1'b1, 1'b0, 1'b1, 10'd5, 32'h00E00A6F, 1'b0, 1'b0, NOP,          32'h1002, 2'b01, 32'd7};
    tbl[13] = '{1'b1, 32'h14,   1'b1, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h00E00A6F, 32'h14,   2'b00, 32'd7};
    tbl[14] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 32'h00E00A6F, 32'h14,   2'b00, 32'd7};
    tbl[15] = '{1'b1, 32'h0,    1'b0, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b0, 32'h00E00A6F, 32'h14,   2'b00, 32'd7};
    tbl[16] = '{1'b1, 32'h8,    1'b0, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 32'h0074AE03, 32'h8,    2'b00, 32'd7};

    rstn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = 10'd0; load_data = 32'h0;
    @(posedge clk); #1;
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.resp_data",  resp_data, 32'h0);
    chk("reset.resp_addr",  resp_addr, 32'h0);
    chk("reset.resp_fault", 32'(resp_fault), 32'd0);
    chk("reset.fetch_cnt",  fetch_cnt, 32'd0);
    chk("reset.req_ready",  32'(req_ready), 32'd1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rv, tbl[i].ra, tbl[i].rr, tbl[i].fl, tbl[i].le, tbl[i].la, tbl[i].ld, rdy);
      chk($sformatf("tbl%0d.req_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d.resp_data", i), resp_data, tbl[i].e_data);
      chk($sformatf("tbl%0d.resp_addr", i), resp_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.resp_fault", i), 32'(resp_fault), 32'(tbl[i].e_f));
      chk($sformatf("tbl%0d.fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
    end

    // Back-pressure: response for 0x4 held for three cycles, then released.
    step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0, rdy);
    chk("bp.first_data", resp_data, 32'h00132423);
    chk("bp.first_cnt", fetch_cnt, 32'd8);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, rdy);
      chk("bp.hold_ready", 32'(rdy), 32'd0);
      chk("bp.hold_data", resp_data, 32'h00132423);
      chk("bp.hold_valid", 32'(resp_valid), 32'd1);
    end
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0, rdy);
    chk("bp.release_ready", 32'(rdy), 32'd1);
    chk("bp.release_cnt", fetch_cnt, 32'd9);
    chk("bp.release_data", resp_data, 32'h00848967);
    chk("bp.release_addr", resp_addr, 32'hC);

    // Asynchronous reset with a response pending.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, rdy);
    chk("ar.pending", 32'(resp_valid), 32'd1);
    #3 rstn = 1'b0;
    #1;
    chk("ar.resp_valid", 32'(resp_valid), 32'd0);
    chk("ar.resp_data",  resp_data, 32'h0);
    chk("ar.resp_addr",  resp_addr, 32'h0);
    chk("ar.resp_fault", 32'(resp_fault), 32'd0);
    chk("ar.fetch_cnt",  fetch_cnt, 32'd0);
    chk("ar.req_ready",  32'(req_ready), 32'd1);
    model_reset();
    #10 rstn = 1'b1;
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0, rdy);
    chk("ar.refetch_data", resp_data, 32'h00500093);
    chk("ar.refetch_valid", 32'(resp_valid), 32'd1);

    // Randomized traffic over the low 64 words plus fault addresses.
    for (int n = 0; n < 800; n++) begin
      rv = ($urandom_range(3) != 0);
      rr = ($urandom_range(3) != 0);
      fl = ($urandom_range(15) == 0);
      le = ($urandom_range(7) == 0);
      r  = int'($urandom_range(15));
      if (r == 0)      ra = {24'h0, 6'($urandom), 2'($urandom_range(3, 1))};
      else if (r == 1) ra = $urandom | 32'h0000_1000;
      else             ra = {24'h0, 6'($urandom), 2'b00};
      step(rv, ra, rr, fl, le, 10'($urandom_range(63)), $urandom, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
